// File: rtl/tb_ctl_pkg.sv
// Shared definitions for the byte-wide JTAG command protocol.
// Holds the opcode nibbles, header length, default sync/fill bytes and the
// command state enum used by both the host encoder and the remote decoder.
package tb_ctl_pkg;

  localparam logic [3:0] CMD_READ  = 4'h0;
  localparam logic [3:0] CMD_WRITE = 4'h1;

  // cmd, addr0..addr3, count
  localparam logic [2:0] HDR_LEN = 3'd6;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StWdata,
    StRdata,
    StDone
  } tb_state_e;

  // First header byte: opcode nibble, space, reserved zero bit.
  function automatic logic [7:0] cmd_byte(input logic write, input logic [2:0] space);
    return {(write ? CMD_WRITE : CMD_READ), space, 1'b0};
  endfunction

endpackage

// File: rtl/tb_word_packer.sv
// Lane tracking and word <-> byte conversion for the command encoder.
// Ports:
//   sysclk, sys_rstn         clock, synchronous active-low reset
//   start, start_lane        begin a command, lane counter loads start_lane
//   wr_pop, wr_data          capture the next write word
//   wr_adv                   current write lane has been sent
//   wr_have, wr_byte         a write word is held / its current lane
//   rd_push, rd_byte         read data byte arriving at the current lane
//   rd_last                  rd_push carries the final data byte
//   rd_valid/rd_ready        packed read word handshake
//   rd_data, rd_bytesel      packed word and its valid lanes
module tb_word_packer (
  input  logic        sysclk,
  input  logic        sys_rstn,
  input  logic        start,
  input  logic [1:0]  start_lane,
  input  logic        wr_pop,
  input  logic [31:0] wr_data,
  input  logic        wr_adv,
  output logic        wr_have,
  output logic [7:0]  wr_byte,
  input  logic        rd_push,
  input  logic [7:0]  rd_byte,
  input  logic        rd_last,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic [3:0]  rd_bytesel
);

  logic [1:0]  lane_q;
  logic [31:0] wr_word_q;
  logic        wr_have_q;
  logic [31:0] rd_data_q;
  logic [3:0]  rd_sel_q;
  logic        rd_valid_q;

  always_ff @(posedge sysclk) begin
    if (!sys_rstn) begin
      lane_q     <= 2'd0;
      wr_word_q  <= 32'd0;
      wr_have_q  <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_sel_q   <= 4'd0;
      rd_valid_q <= 1'b0;
    end else if (start) begin
      lane_q     <= start_lane;
      wr_have_q  <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_sel_q   <= 4'd0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_adv || rd_push) lane_q <= lane_q + 2'd1;

      if (wr_pop) begin
        wr_word_q <= wr_data;
        wr_have_q <= 1'b1;
      end else if (wr_adv && lane_q == 2'd3) begin
        // Word exhausted; the next one is fetched only if more bytes follow.
        wr_have_q <= 1'b0;
      end

      if (rd_valid_q && rd_ready) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= 32'd0;
        rd_sel_q   <= 4'd0;
      end
      if (rd_push) begin
        rd_data_q[{lane_q, 3'b000} +: 8] <= rd_byte;
        rd_sel_q[lane_q]                 <= 1'b1;
        if (lane_q == 2'd3 || rd_last) rd_valid_q <= 1'b1;
      end
    end
  end

  assign wr_have    = wr_have_q;
  assign wr_byte    = wr_word_q[{lane_q, 3'b000} +: 8];
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_bytesel = rd_sel_q;

endmodule

// File: rtl/tb_cmd_enc.sv
// Host-side command encoder for the byte-wide JTAG command protocol.
// Turns a read/write request into cmd/addr/count/data bytes on the tx link and
// parses the lock-step rx stream (sync, status, read data).
// Ports:
//   sysclk, sys_rstn               clock, synchronous active-low reset
//   req_*                          request (write, space, addr, len; len 0 = 256)
//   wr_valid/wr_ready/wr_data      write words, wr_ready pulses on consume
//   rd_valid/rd_ready/rd_data/rd_bytesel  packed read words
//   tx_valid/tx_ready/tx_byte      bytes to the link
//   rx_valid/rx_byte               one response byte per accepted tx byte
//   status, done, err              async status, end pulse, sticky sync error
module tb_cmd_enc
  import tb_ctl_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        sysclk,
  input  logic        sys_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_space,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic [3:0]  rd_bytesel,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [31:0] status,
  output logic        done,
  output logic        err
);

  tb_state_e   state_q, state_d;
  logic        rdy_en_q;  // holds req_ready low through reset
  logic        pend_q;    // a tx byte is awaiting its rx byte
  logic [2:0]  hdr_idx_q; // header bytes sent
  logic [8:0]  rem_q;     // data bytes remaining
  logic        write_q;
  logic [2:0]  space_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [31:0] status_q;
  logic        err_q;

  logic req_fire, tx_fire, rx_fire;
  logic wr_have, rd_stall, pk_wr_adv, pk_rd_push;
  logic [7:0] wr_byte;

  assign req_ready = rdy_en_q && (state_q == StIdle);
  assign req_fire  = req_valid && req_ready;
  assign tx_fire   = tx_valid && tx_ready;
  // rx outside an outstanding transfer is ignored
  assign rx_fire   = rx_valid && pend_q;
  assign rd_stall  = rd_valid && !rd_ready;
  assign done      = (state_q == StDone);
  assign status    = status_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    tx_valid   = 1'b0;
    tx_byte    = FILL_BYTE;
    wr_ready   = 1'b0;
    pk_wr_adv  = 1'b0;
    pk_rd_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_fire) state_d = StHdr;
      end
      StHdr: begin
        tx_valid = !pend_q && (hdr_idx_q < HDR_LEN);
        unique case (hdr_idx_q)
          3'd0:    tx_byte = cmd_byte(write_q, space_q);
          3'd1:    tx_byte = addr_q[7:0];
          3'd2:    tx_byte = addr_q[15:8];
          3'd3:    tx_byte = addr_q[23:16];
          3'd4:    tx_byte = addr_q[31:24];
          3'd5:    tx_byte = len_q;
          default: tx_byte = FILL_BYTE;
        endcase
        if (rx_fire && hdr_idx_q == HDR_LEN) state_d = write_q ? StWdata : StRdata;
      end
      StWdata: begin
        wr_ready  = !wr_have && (rem_q != 9'd0) && wr_valid;
        tx_valid  = !pend_q && wr_have && (rem_q != 9'd0);
        tx_byte   = wr_byte;
        pk_wr_adv = tx_valid && tx_ready;
        if (!pend_q && rem_q == 9'd0) state_d = StDone;
      end
      StRdata: begin
        // Data bytes and the trailing discard byte all go out as FILL_BYTE.
        tx_valid = !pend_q && !rd_stall;
        if (rx_fire) begin
          if (rem_q != 9'd0) pk_rd_push = 1'b1;
          else               state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!sys_rstn) begin
      state_q   <= StIdle;
      rdy_en_q  <= 1'b0;
      pend_q    <= 1'b0;
      hdr_idx_q <= 3'd0;
      rem_q     <= 9'd0;
      write_q   <= 1'b0;
      space_q   <= 3'd0;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      status_q  <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      if (req_fire) begin
        write_q   <= req_write;
        space_q   <= req_space;
        addr_q    <= req_addr;
        len_q     <= req_len;
        rem_q     <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
        hdr_idx_q <= 3'd0;
        pend_q    <= 1'b0;
        err_q     <= 1'b0;
      end
      // tx only goes out with nothing pending, so tx_fire and rx_fire never coincide.
      if (tx_fire) begin
        pend_q <= 1'b1;
        if (state_q == StHdr)   hdr_idx_q <= hdr_idx_q + 3'd1;
        if (state_q == StWdata) rem_q     <= rem_q - 9'd1;
      end else if (rx_fire) begin
        pend_q <= 1'b0;
      end
      if (rx_fire && state_q == StHdr) begin
        // hdr_idx_q already counts the byte this rx answers, so rx index = hdr_idx_q - 1.
        unique case (hdr_idx_q)
          3'd1:    if (rx_byte != SYNC_BYTE) err_q <= 1'b1;
          3'd2:    status_q[7:0]   <= rx_byte;
          3'd3:    status_q[15:8]  <= rx_byte;
          3'd4:    status_q[23:16] <= rx_byte;
          3'd5:    status_q[31:24] <= rx_byte;
          default: ;
        endcase
      end
      if (rx_fire && state_q == StRdata && rem_q != 9'd0) rem_q <= rem_q - 9'd1;
    end
  end

  tb_word_packer u_packer (
    .sysclk     (sysclk),
    .sys_rstn   (sys_rstn),
    .start      (req_fire),
    .start_lane (req_addr[1:0]),
    .wr_pop     (wr_ready),
    .wr_data    (wr_data),
    .wr_adv     (pk_wr_adv),
    .wr_have    (wr_have),
    .wr_byte    (wr_byte),
    .rd_push    (pk_rd_push),
    .rd_byte    (rx_byte),
    .rd_last    (rem_q == 9'd1),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_bytesel (rd_bytesel)
  );

endmodule

// File: tb/tb_tb_cmd_enc.sv
module tb_tb_cmd_enc;
  localparam logic [7:0] FILL = 8'hFF;
  localparam logic [7:0] SYNC = 8'h5A;

  logic        sysclk = 1'b0;
  logic        sys_rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0]  req_space = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [7:0]  req_len = 8'd0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = 32'd0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic [3:0]  rd_bytesel;
  logic        tx_valid, tx_ready = 1'b0;
  logic [7:0]  tx_byte;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic [31:0] status;
  logic        done, err;

  always #5 sysclk = ~sysclk;

  tb_cmd_enc dut (
    .sysclk(sysclk), .sys_rstn(sys_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_space(req_space), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_bytesel(rd_bytesel),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .status(status), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural expectations for the command in flight.
  logic [7:0]  exp_tx[$];
  logic [7:0]  rsp_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] exp_rd_data[$];
  logic [3:0]  exp_rd_sel[$];
  logic [31:0] dir_words[$];
  logic [7:0]  dir_data[$];
  logic [31:0] exp_status = 32'd0;
  bit          exp_err = 1'b0;
  int          exp_pops, exp_rdw, exp_txn;

  int          rx_dn = 0;
  logic [7:0]  rx_hold = 8'd0;
  int          hold_left = 0;
  int          tx_cnt, wr_pops, rd_cnt, done_cnt;
  bit          req_pend = 1'b0;
  bit          err_clr_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1ns later (stable until the rising edge).
  task automatic cycle();
    bit acc;
    logic [31:0] ed;
    @(negedge sysclk);
    tx_ready  = ($urandom_range(0, 3) != 0);
    rd_ready  = (hold_left > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
    req_valid = req_pend;
    if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      wr_valid = 1'b1;
      wr_data  = wr_q[0];
    end else begin
      wr_valid = 1'b0;
      wr_data  = $urandom;
    end
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    if (rx_dn > 0) begin
      rx_dn--;
      if (rx_dn == 0) begin
        rx_valid = 1'b1;
        rx_byte  = rx_hold;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      rx_valid = 1'b1;  // stray strobe with nothing outstanding
    end
    #1;
    acc = req_valid && req_ready;
    if (acc) req_pend = 1'b0;
    if (err_clr_chk) begin
      check("err_cleared_on_accept", {31'd0, err}, 32'd0);
      err_clr_chk = 1'b0;
    end
    if (acc) err_clr_chk = 1'b1;
    if (rd_valid && !rd_ready) check("tx_stall_while_rd_held", {31'd0, tx_valid}, 32'd0);
    if (tx_valid && tx_ready) begin
      tx_cnt++;
      check("tx_while_outstanding", {31'd0, rx_dn != 0}, 32'd0);
      if (exp_tx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got byte %h expected no tx", tx_byte);
      end else begin
        check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_tx.pop_front()});
      end
      rx_hold = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'($urandom);
      rx_dn   = $urandom_range(1, 3);
    end
    if (wr_ready) begin
      wr_pops++;
      check("wr_ready_needs_valid", {31'd0, wr_valid}, 32'd1);
      if (wr_q.size() > 0) void'(wr_q.pop_front());
    end
    if (rd_valid && rd_ready) begin
      rd_cnt++;
      if (exp_rd_data.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %h expected no word", rd_data);
      end else begin
        ed = exp_rd_data.pop_front();
        check("rd_data", rd_data, ed);
        check("rd_bytesel", {28'd0, rd_bytesel}, {28'd0, exp_rd_sel.pop_front()});
      end
    end
    if (hold_left > 0 && rd_valid) hold_left--;
    if (done) done_cnt++;
  endtask

  // Build the expected byte streams for one command from the protocol rules.
  task automatic setup(input bit wr, input logic [2:0] sp, input logic [31:0] ad,
                       input logic [7:0] ln, input bit bad, input logic [31:0] st);
    int L, l0, nw, idx, ln_i;
    logic [7:0]  d;
    logic [31:0] w;
    logic [31:0] words[$];
    L  = (ln == 8'd0) ? 256 : int'(ln);
    l0 = int'(ad[1:0]);
    nw = (l0 + L + 3) / 4;
    exp_tx.delete(); rsp_q.delete(); wr_q.delete();
    exp_rd_data.delete(); exp_rd_sel.delete();
    exp_tx.push_back({(wr ? 4'h1 : 4'h0), sp, 1'b0});
    for (int b = 0; b < 4; b++) exp_tx.push_back(ad[8*b +: 8]);
    exp_tx.push_back(ln);
    d = 8'($urandom);
    if (d == SYNC) d = 8'h00;
    rsp_q.push_back(bad ? d : SYNC);
    for (int b = 0; b < 4; b++) rsp_q.push_back(st[8*b +: 8]);
    rsp_q.push_back(8'($urandom));
    if (wr) begin
      for (int i = 0; i < nw; i++)
        words.push_back((dir_words.size() > 0) ? dir_words.pop_front() : $urandom);
      wr_q = words;
      for (int i = 0; i < L; i++) begin
        w = words[(l0 + i) / 4];
        exp_tx.push_back(w[8*((l0 + i) % 4) +: 8]);
        rsp_q.push_back(8'($urandom));
      end
    end else begin
      for (int i = 0; i < nw; i++) begin
        exp_rd_data.push_back(32'd0);
        exp_rd_sel.push_back(4'd0);
      end
      for (int i = 0; i <= L; i++) exp_tx.push_back(FILL);
      for (int i = 0; i < L; i++) begin
        d = (dir_data.size() > 0) ? dir_data.pop_front() : 8'($urandom);
        rsp_q.push_back(d);
        idx  = (l0 + i) / 4;
        ln_i = (l0 + i) % 4;
        w = exp_rd_data[idx];
        w[8*ln_i +: 8] = d;
        exp_rd_data[idx] = w;
        exp_rd_sel[idx] = exp_rd_sel[idx] | (4'd1 << ln_i);
      end
      rsp_q.push_back(8'($urandom));
    end
    req_write  = wr;
    req_space  = sp;
    req_addr   = ad;
    req_len    = ln;
    exp_err    = bad;
    exp_status = st;
    exp_pops   = wr ? nw : 0;
    exp_rdw    = wr ? 0 : nw;
    exp_txn    = 6 + L + (wr ? 0 : 1);
  endtask

  task automatic run_cmd(input string tag);
    int n;
    tx_cnt = 0; wr_pops = 0; rd_cnt = 0; done_cnt = 0;
    req_pend = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 6000) begin
      cycle();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", tag, n);
    end
    cycle();
    cycle();
    check({tag, "_done_once"}, done_cnt, 32'd1);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_tx_count"}, tx_cnt, exp_txn);
    check({tag, "_tx_left"}, exp_tx.size(), 32'd0);
    check({tag, "_wr_pops"}, wr_pops, exp_pops);
    check({tag, "_rd_words"}, rd_cnt, exp_rdw);
    check({tag, "_status"}, status, exp_status);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_byte"}, {24'd0, tx_byte}, {24'd0, FILL});
    check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
    check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
    check({tag, "_rd_bytesel"}, {28'd0, rd_bytesel}, 32'd0);
    check({tag, "_status"}, status, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit_w [14];
    int n;
    lit_w = '{8'h14, 8'h04, 8'h00, 8'h00, 8'h10, 8'h08,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    repeat (3) cycle();
    reset_checks("rst");
    sys_rstn = 1'b1;
    cycle();
    check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Directed write: two words, lane-0 start.
    dir_words.push_back(32'h44332211);
    dir_words.push_back(32'h88776655);
    setup(1'b1, 3'd2, 32'h1000_0004, 8'd8, 1'b0, $urandom);
    check("model_wr_len", exp_tx.size(), 32'd14);
    for (int i = 0; i < 14; i++) check("model_wr_byte", {24'd0, exp_tx[i]}, {24'd0, lit_w[i]});
    check("model_wr_pops", exp_pops, 32'd2);
    run_cmd("wr8");

    // Directed read from lane 1, with known status bytes.
    dir_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    setup(1'b0, 3'd0, 32'h0000_0001, 8'd4, 1'b0, 32'h12345678);
    check("model_rd_w0", exp_rd_data[0], 32'hCCBBAA00);
    check("model_rd_s0", {28'd0, exp_rd_sel[0]}, 32'hE);
    check("model_rd_w1", exp_rd_data[1], 32'h000000DD);
    check("model_rd_s1", {28'd0, exp_rd_sel[1]}, 32'h1);
    check("model_rd_txn", exp_txn, 32'd11);
    check("model_status_b1", {24'd0, rsp_q[1]}, 32'h78);
    check("model_status_b4", {24'd0, rsp_q[4]}, 32'h12);
    run_cmd("rd4");

    // len 0 means 256 bytes.
    setup(1'b0, 3'd5, 32'h0000_0100, 8'd0, 1'b0, $urandom);
    check("model_len0_txn", exp_txn, 32'd263);
    check("model_len0_words", exp_rdw, 32'd64);
    run_cmd("rd256");

    // Bad sync sets err; the following accept clears it.
    setup(1'b1, 3'd7, $urandom, 8'd5, 1'b1, $urandom);
    run_cmd("badsync");
    setup(1'b0, 3'd1, $urandom, 8'd3, 1'b0, $urandom);
    run_cmd("after_bad");

    // Hold rd_ready low across several words.
    hold_left = 15;
    setup(1'b0, 3'd3, 32'h0000_0042, 8'd12, 1'b0, $urandom);
    run_cmd("rdhold");
    hold_left = 0;

    for (int k = 0; k < 10; k++) begin
      setup($urandom_range(0, 1), 3'($urandom), $urandom, 8'($urandom_range(1, 24)),
            ($urandom_range(0, 3) == 0), $urandom);
      run_cmd("rand");
    end

    // Abort a write part-way through.
    setup(1'b1, 3'd4, 32'h0000_0003, 8'd20, 1'b0, $urandom);
    tx_cnt = 0; wr_pops = 0; rd_cnt = 0; done_cnt = 0;
    req_pend = 1'b1;
    n = 0;
    while (tx_cnt < 9 && n < 2000) begin
      cycle();
      n++;
    end
    check("abort_reached_data", {31'd0, tx_cnt >= 9}, 32'd1);
    sys_rstn = 1'b0;
    rx_dn = 0;
    req_pend = 1'b0;
    exp_tx.delete(); rsp_q.delete(); wr_q.delete();
    exp_rd_data.delete(); exp_rd_sel.delete();
    cycle();
    cycle();
    reset_checks("abort");
    sys_rstn = 1'b1;
    cycle();
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);

    setup(1'b1, 3'd6, $urandom, 8'd7, 1'b0, $urandom);
    run_cmd("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
